// File: rtl/data_mem_responder.sv
// data_mem_responder: arbitrates two store ports (a, b) and one load port (c)
// onto a single-ported word array, answering each accepted request after a
// fixed LAT-cycle pipeline. A zeroing sweep runs after every reset.
module data_mem_responder #(
    parameter int DEPTH        = 256,
    parameter int LAT          = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_a,
    input  logic        req_valid_b,
    input  logic        req_valid_c,
    output logic        req_ready_a,
    output logic        req_ready_b,
    output logic        req_ready_c,
    input  logic        req_write_a,
    input  logic        req_write_b,
    input  logic        req_write_c,
    input  logic [31:0] req_addr_a,
    input  logic [31:0] req_addr_b,
    input  logic [31:0] req_addr_c,
    input  logic [31:0] req_wdata_a,
    input  logic [31:0] req_wdata_b,
    input  logic [31:0] req_wdata_c,
    output logic        resp_valid,
    output logic [1:0]  resp_port,
    output logic        resp_write,
    output logic [31:0] resp_addr,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        init_busy
);

    localparam int AW = $clog2(DEPTH);
    // Stage 0 rdata comes straight from the array read register, so only the
    // later stages need their own rdata storage.
    localparam int RL = (LAT > 1) ? LAT - 1 : 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t        state_reg;
    logic [AW-1:0] init_idx_reg;
    logic          init_busy_reg;
    logic [2:0]    starve_cnt_reg;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   rd_reg;

    logic [2:0]    valid_vec;
    logic [2:0]    write_vec;
    logic [2:0]    oor_vec;
    logic [2:0]    grant_vec;
    logic [31:0]   addr_arr  [3];
    logic [31:0]   wdata_arr [3];

    logic          accept;
    logic          starve;
    logic [1:0]    sel_port;
    logic          sel_write;
    logic          sel_oor;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic [AW-1:0] sel_idx;

    logic          st_valid_reg [LAT];
    logic [1:0]    st_port_reg  [LAT];
    logic          st_write_reg [LAT];
    logic [31:0]   st_addr_reg  [LAT];
    logic          st_err_reg   [LAT];
    logic [31:0]   st_rdata_reg [RL];
    logic [31:0]   s0_rdata;

    assign valid_vec    = {req_valid_c, req_valid_b, req_valid_a};
    assign write_vec    = {req_write_c, req_write_b, req_write_a};
    assign addr_arr[0]  = req_addr_a;
    assign addr_arr[1]  = req_addr_b;
    assign addr_arr[2]  = req_addr_c;
    assign wdata_arr[0] = req_wdata_a;
    assign wdata_arr[1] = req_wdata_b;
    assign wdata_arr[2] = req_wdata_c;

    // Any address bit above the word index marks the access out of range.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_port
            assign oor_vec[gi] = |addr_arr[gi][31:AW+2];
        end
    endgenerate

    // One grant per cycle: a > b > c, or c > a > b once c has starved.
    always_comb begin
        starve    = (starve_cnt_reg >= 3'(STARVE_LIMIT));
        grant_vec = 3'b000;
        if (state_reg == RUN) begin
            if (starve && valid_vec[2])
                grant_vec = 3'b100;
            else if (valid_vec[0])
                grant_vec = 3'b001;
            else if (valid_vec[1])
                grant_vec = 3'b010;
            else if (valid_vec[2])
                grant_vec = 3'b100;
        end
    end

    assign req_ready_a = grant_vec[0];
    assign req_ready_b = grant_vec[1];
    assign req_ready_c = grant_vec[2];
    assign accept      = |grant_vec;

    // Steer the granted port's request fields onto the shared access path.
    always_comb begin
        sel_port  = 2'd0;
        sel_write = write_vec[0];
        sel_oor   = oor_vec[0];
        sel_addr  = addr_arr[0];
        sel_wdata = wdata_arr[0];
        if (grant_vec[1]) begin
            sel_port  = 2'd1;
            sel_write = write_vec[1];
            sel_oor   = oor_vec[1];
            sel_addr  = addr_arr[1];
            sel_wdata = wdata_arr[1];
        end else if (grant_vec[2]) begin
            sel_port  = 2'd2;
            sel_write = write_vec[2];
            sel_oor   = oor_vec[2];
            sel_addr  = addr_arr[2];
            sel_wdata = wdata_arr[2];
        end
    end

    assign sel_idx = sel_addr[AW+1:2];

    // Word array: sweep writes during INIT, stores in RUN, registered load read.
    always_ff @(posedge clk) begin
        if (state_reg == INIT)
            mem[init_idx_reg] <= '0;
        else if (accept && sel_write && !sel_oor)
            mem[sel_idx] <= sel_wdata;
        if (accept && !sel_write)
            rd_reg <= mem[sel_idx];
    end

    // INIT/RUN control, sweep index and starvation counter for port c.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= INIT;
            init_idx_reg   <= '0;
            init_busy_reg  <= 1'b1;
            starve_cnt_reg <= 3'd0;
        end else begin
            case (state_reg)
                INIT: begin
                    starve_cnt_reg <= 3'd0;
                    init_idx_reg   <= init_idx_reg + 1'b1;
                    if (init_idx_reg == AW'(DEPTH - 1)) begin
                        state_reg     <= RUN;
                        init_busy_reg <= 1'b0;
                    end
                end
                default: begin
                    if (!valid_vec[2] || grant_vec[2])
                        starve_cnt_reg <= 3'd0;
                    else if (starve_cnt_reg != 3'd7)
                        starve_cnt_reg <= starve_cnt_reg + 3'd1;
                end
            endcase
        end
    end

    assign init_busy = init_busy_reg;

    // Loads that are valid, in range and not stores expose the read value.
    assign s0_rdata = (st_valid_reg[0] && !st_write_reg[0] && !st_err_reg[0]) ? rd_reg : '0;

    // Response pipeline: stage 0 is loaded on the accept edge, then shifts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                st_valid_reg[i] <= 1'b0;
                st_port_reg[i]  <= 2'd0;
                st_write_reg[i] <= 1'b0;
                st_addr_reg[i]  <= '0;
                st_err_reg[i]   <= 1'b0;
            end
            for (int j = 0; j < RL; j++)
                st_rdata_reg[j] <= '0;
        end else begin
            st_valid_reg[0] <= accept;
            st_port_reg[0]  <= accept ? sel_port : 2'd0;
            st_write_reg[0] <= accept & sel_write;
            st_addr_reg[0]  <= accept ? sel_addr : '0;
            st_err_reg[0]   <= accept & sel_oor;
            for (int i = 1; i < LAT; i++) begin
                st_valid_reg[i] <= st_valid_reg[i-1];
                st_port_reg[i]  <= st_port_reg[i-1];
                st_write_reg[i] <= st_write_reg[i-1];
                st_addr_reg[i]  <= st_addr_reg[i-1];
                st_err_reg[i]   <= st_err_reg[i-1];
            end
            st_rdata_reg[0] <= s0_rdata;
            for (int j = 1; j < RL; j++)
                st_rdata_reg[j] <= st_rdata_reg[j-1];
        end
    end

    assign resp_valid = st_valid_reg[LAT-1];
    assign resp_port  = st_port_reg[LAT-1];
    assign resp_write = st_write_reg[LAT-1];
    assign resp_addr  = st_addr_reg[LAT-1];
    assign resp_err   = st_err_reg[LAT-1];
    assign resp_rdata = (LAT == 1) ? s0_rdata : st_rdata_reg[RL-1];

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the data-memory request protocol used by the retire stage (two store ports) and the load functional unit (one load port). It arbitrates three request channels, performs one word access per cycle against an internal word array, and returns a response after a fixed pipeline latency. After every reset it runs a zeroing sweep so that memory contents are deterministic before the first access.

## Interface
Parameters:
- DEPTH — default 256 — number of 32-bit words; power of two, 16..1024.
- LAT — default 2 — request-to-response latency in cycles, 1..4.
- STARVE_LIMIT — default 4 — number of consecutive lost arbitrations on port c before c is forced to win, 1..7.

Ports:
- clk — in — 1 — single clock; all state updates on posedge.
- reset — in — 1 — asynchronous, active-high.
- req_valid_{a,b,c} — in — 1 each — request present on that port.
- req_ready_{a,b,c} — out — 1 each — grant. A request is accepted on a posedge where valid and ready are both high.
- req_write_{a,b,c} — in — 1 each — 1 = store, 0 = load.
- req_addr_{a,b,c} — in — 32 each — byte address.
- req_wdata_{a,b,c} — in — 32 each — store data.
- resp_valid — out — 1 — response present; one-cycle pulse.
- resp_port — out — 2 — source of the response: 0 = a, 1 = b, 2 = c.
- resp_write — out — 1 — echoes the request type.
- resp_addr — out — 32 — echoes the request address.
- resp_rdata — out — 32 — load data; 0 for stores and errors.
- resp_err — out — 1 — address out of range.
- init_busy — out — 1 — zeroing sweep in progress.

## Operation
- FSM states are INIT and RUN. Asserting reset forces INIT with the sweep index at 0.
- INIT: write 0 to word[idx] and increment idx each cycle. After idx reaches DEPTH-1, transition to RUN. All req_ready signals are 0 and init_busy is 1 throughout INIT.
- RUN: at most one grant per cycle, and req_ready is combinational from the valids.
  - Default priority is a > b > c. Because a wins over b, same-cycle retire stores commit in program order.
  - Starvation: a 3-bit counter increments on each cycle where c is valid and not granted. When the counter reaches STARVE_LIMIT, priority becomes c > a > b. The counter clears whenever c is granted or c is not valid.
  - A port that is not granted holds its request; the responder never drops a request it has not accepted.
- Addressing: word index = addr[log2(DEPTH)+1:2], and addr[1:0] are ignored. If any addr bit above log2(DEPTH)+1 is set, the access is out of range:
  - a store is discarded;
  - a load returns 0;
  - resp_err = 1.
- A store writes the array on its accept edge. A load reads the array value as of its accept edge, so a load accepted after a store to the same word observes the stored value.
- The response pipeline is LAT stages deep, carrying {valid, port, write, addr, rdata, err}. There is no backpressure on responses.

## Timing
- Reset values: req_ready_* = 0, resp_valid = 0, resp_port = 0, resp_write = 0, resp_addr = 0, resp_rdata = 0, resp_err = 0, init_busy = 1, starve counter = 0, all pipeline stages invalid.
- INIT lasts exactly DEPTH cycles after reset deasserts. The first possible accept is on posedge DEPTH+1.
- A request accepted at posedge N produces resp_valid high during the cycle following posedge N+LAT-1, i.e. it is sampled at posedge N+LAT.
- Responses are produced in accept order, at most one per cycle. Back-to-back accepts produce back-to-back responses.
- Reset mid-operation: in-flight responses are discarded with no resp_valid pulse, and a fresh INIT re-zeroes memory.
- A reset during INIT restarts the sweep at idx 0.

## Test plan
- Reset released, DEPTH=256: init_busy stays high for 256 cycles and req_ready_a stays 0 even with valid high. The first accept occurs on the next edge, and a load of 0x40 returns resp_rdata=0.
- Store 0xDEADBEEF to 0x10 via a, then a load of 0x10 via c one cycle later (LAT=2): the c response arrives 2 cycles after its accept with rdata=0xDEADBEEF, port=2, err=0.
- a, b and c all valid in the same cycle: grant order is a, b, c on consecutive cycles, with responses in the same order carrying port 0, 1, 2.
- a and b held valid continuously with c valid and STARVE_LIMIT=4: c is granted on the 5th cycle after becoming valid, and the counter then reads 0.
- Load of 0x0000_0400 with DEPTH=256: resp_err=1 and rdata=0. A store to 0x0000_0400 with data 5 leaves word 0 unchanged when read back.
- Reset pulse while two loads are in flight: no resp_valid appears, init_busy reasserts for DEPTH cycles, and the previously stored word reads back 0.
